seg_digit_demux: RTL

Write-side distributor for the seven-segment display path: accepts one N-bit segment pattern per handshake and steers it into one of DIGITS per-digit holding registers. Target digit is an explicit select or an internal auto-advancing pointer. Outputs all digits in parallel to the downstream select/scan logic. A multi-cycle clear sequence blanks every digit one per cycle.

---
 rtl/seg_digit_demux.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seg_digit_demux.sv
// rtl/seg_digit_demux.sv - steers handshaked segment patterns into per-digit holding registers
module seg_digit_demux #(
    parameter int          N      = 7,
    parameter int          DIGITS = 4,
    parameter logic [N-1:0] BLANK = {N{1'b1}},
    localparam int         SW     = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SW-1:0]         in_sel,
    input  logic                  in_auto,
    input  logic                  clear,
    output logic [DIGITS*N-1:0]   out_bus,
    output logic [DIGITS-1:0]     out_written,
    output logic [SW-1:0]         ptr,
    output logic                  frame_done,
    output logic                  sel_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CLR  = 1'b1;

    // Digit count widened by one bit so an out-of-range select can be detected.
    localparam logic [SW:0]   DIGITS_W = (SW+1)'(DIGITS);
    localparam logic [SW-1:0] LAST     = SW'(DIGITS - 1);

    logic [0:0]    state;
    logic [SW-1:0] ccnt;

    logic          xfer;
    logic          sel_ok;
    logic          wr_en;
    logic [SW-1:0] wr_idx;
    logic [N-1:0]  wr_val;
    logic          wr_mark;

    assign in_ready = (state == S_IDLE) && !clear;
    assign xfer     = in_valid && in_ready;
    assign sel_ok   = {1'b0, in_sel} < DIGITS_W;

    // Pick the single digit register touched this cycle: clear walk, auto pointer or explicit select.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ptr;
        wr_val  = in_data;
        wr_mark = 1'b0;
        if (state == S_CLR) begin
            wr_en   = 1'b1;
            wr_idx  = ccnt;
            wr_val  = BLANK;
            wr_mark = 1'b0;
        end else if (xfer) begin
            if (in_auto) begin
                wr_en   = 1'b1;
                wr_idx  = ptr;
                wr_mark = 1'b1;
            end else if (sel_ok) begin
                wr_en   = 1'b1;
                wr_idx  = in_sel;
                wr_mark = 1'b1;
            end
        end
    end

    // Digit registers and written flags; reset restores every digit to the blank pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bus     <= {DIGITS{BLANK}};
            out_written <= '0;
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                if (wr_en && (wr_idx == SW'(d))) begin
                    out_bus[d*N +: N] <= wr_val;
                    out_written[d]    <= wr_mark;
                end
            end
        end
    end

    // Control: pointer advance, clear walk and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ccnt       <= '0;
            ptr        <= '0;
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        state <= S_CLR;
                        ccnt  <= '0;
                    end else if (xfer) begin
                        if (in_auto) begin
                            if (ptr == LAST) begin
                                ptr        <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end else if (!sel_ok) begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    // A clear arriving here is ignored; the walk always runs to the last digit.
                    if (ccnt == LAST) begin
                        state <= S_IDLE;
                        ccnt  <= '0;
                        ptr   <= '0;
                    end else begin
                        ccnt <= ccnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
